// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = A - B - i_borrow), DIGIT_W bits per
// clock LSB first through one shared digit stage, valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             i_borrow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             o_borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT_W;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int DIG_SUB_W = DIGIT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  generate
    if (DIGIT_W < 1 || DIGIT_W > WIDTH || (WIDTH % DIGIT_W) != 0) begin : g_bad_param
      $error("serial_subtractor: DIGIT_W must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg, res_reg;
  logic               borrow_reg, a_msb_reg, b_msb_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DIGIT_W:0]   dig_sub;
  logic [DIGIT_W-1:0] dig_d;
  logic               dig_bout;
  logic [WIDTH-1:0]   res_next;
  logic               last_step;

  // Shared digit stage: the extra top bit of the (DIGIT_W+1)-bit difference is the borrow.
  always_comb begin
    dig_sub   = {1'b0, a_reg[DIGIT_W-1:0]} - {1'b0, b_reg[DIGIT_W-1:0]}
              - DIG_SUB_W'(borrow_reg);
    dig_bout  = dig_sub[DIGIT_W];
    dig_d     = dig_sub[DIGIT_W-1:0];
    res_next  = (res_reg >> DIGIT_W) | (WIDTH'(dig_d) << (WIDTH - DIGIT_W));
    last_step = (cnt_reg == LAST);
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      cnt_reg    <= '0;
      diff       <= '0;
      o_borrow   <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= i_borrow;
            a_msb_reg  <= A[WIDTH-1];
            b_msb_reg  <= B[WIDTH-1];
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          a_reg      <= a_reg >> DIGIT_W;
          b_reg      <= b_reg >> DIGIT_W;
          res_reg    <= res_next;
          borrow_reg <= dig_bout;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          // Visible result only changes on the final digit, so DONE holds it stable.
          if (last_step) begin
            diff     <= res_next;
            o_borrow <= dig_bout;
            zero     <= (res_next == '0);
            ovf      <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ res_next[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
